// File: rtl/enc_period_snapshot_ctrl_if.sv
// Host-side interface of the encoder period snapshot controller.
// Carries the snapshot req/ack handshake and the committed read path.
//   snap_req  : snapshot request level (host -> ctrl)
//   snap_ack  : snapshot committed, held while snap_req stays high
//   busy      : controller is sampling or committing
//   rd_sel    : read channel select (host -> ctrl)
//   rd_data   : committed period word of rd_sel, one cycle after rd_sel
//   rd_valid  : at least one snapshot committed since reset
//   stale     : committed per-channel stale flags
//   seq       : committed snapshot sequence number
interface enc_period_snapshot_ctrl_if #(
   parameter int unsigned NUM_CH = 4,
   parameter int unsigned DW     = 32,
   parameter int unsigned CHW    = 2
);
   logic              snap_req;
   logic              snap_ack;
   logic              busy;
   logic [CHW-1:0]    rd_sel;
   logic [DW-1:0]     rd_data;
   logic              rd_valid;
   logic [NUM_CH-1:0] stale;
   logic [7:0]        seq;

   modport master (
      output snap_req, rd_sel,
      input  snap_ack, busy, rd_data, rd_valid, stale, seq
   );

   modport slave (
      input  snap_req, rd_sel,
      output snap_ack, busy, rd_data, rd_valid, stale, seq
   );
endinterface

// File: rtl/enc_period_snapshot_ctrl.sv
// Encoder period snapshot controller.
// On a rising edge of snap_req, walks the channels one per cycle into a
// shadow buffer, commits the shadow atomically into the read buffer and
// acknowledges. A per-channel watchdog flags channels that have not been
// refreshed for STALE_MAX cycles.
//   clk_fast  : measurement clock
//   reset     : asynchronous, active-low
//   ch_period : per-channel period words, channel k at [k*DW +: DW]
//   ch_update : per-channel refresh pulse
//   bus       : host handshake and read path (slave side)
module enc_period_snapshot_ctrl #(
   parameter int unsigned NUM_CH    = 4,
   parameter int unsigned DW        = 32,
   parameter int unsigned CHW       = 2,
   parameter logic [15:0] STALE_MAX = 16'hFFFF
) (
   input  logic                 clk_fast,
   input  logic                 reset,
   input  logic [NUM_CH*DW-1:0] ch_period,
   input  logic [NUM_CH-1:0]    ch_update,
   enc_period_snapshot_ctrl_if.slave bus
);

   localparam int unsigned WDW = 16;
   localparam logic [CHW-1:0] CI_LAST = CHW'(NUM_CH - 1);

   typedef enum logic [1:0] {
      IDLE,
      SAMPLE,
      COMMIT,
      ACK
   } state_t;

   state_t            state;
   logic [CHW-1:0]    ci;
   logic              snap_req_q;
   logic              snap_ack_q;
   logic              busy_q;
   logic              rd_valid_q;
   logic [7:0]        seq_q;
   logic [NUM_CH-1:0] stale_q;
   logic [DW-1:0]     rd_data_q;
   logic [NUM_CH-1:0] shadow_stale;
   logic [DW-1:0]     shadow  [NUM_CH];
   logic [DW-1:0]     readbuf [NUM_CH];
   logic [WDW-1:0]    wd      [NUM_CH];

   assign bus.snap_ack = snap_ack_q;
   assign bus.busy     = busy_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.seq      = seq_q;
   assign bus.stale    = stale_q;
   assign bus.rd_data  = rd_data_q;

   // Staleness watchdogs: cleared by an update, otherwise count up and saturate.
   always_ff @(posedge clk_fast or negedge reset) begin
      if (!reset) begin
         for (int k = 0; k < NUM_CH; k++) wd[k] <= '0;
      end else begin
         for (int k = 0; k < NUM_CH; k++) begin
            if (ch_update[k])           wd[k] <= '0;
            else if (wd[k] != STALE_MAX) wd[k] <= wd[k] + WDW'(1);
         end
      end
   end

   // Snapshot sequencer with registered handshake/status outputs.
   always_ff @(posedge clk_fast or negedge reset) begin
      if (!reset) begin
         state        <= IDLE;
         ci           <= '0;
         snap_req_q   <= 1'b0;
         snap_ack_q   <= 1'b0;
         busy_q       <= 1'b0;
         rd_valid_q   <= 1'b0;
         seq_q        <= '0;
         stale_q      <= '0;
         shadow_stale <= '0;
         for (int k = 0; k < NUM_CH; k++) begin
            shadow[k]  <= '0;
            readbuf[k] <= '0;
         end
      end else begin
         snap_req_q <= bus.snap_req;
         case (state)
            IDLE: begin
               if (bus.snap_req && !snap_req_q) begin
                  state  <= SAMPLE;
                  ci     <= '0;
                  busy_q <= 1'b1;
               end
            end
            SAMPLE: begin
               // Stale flag uses the watchdog value before any same-cycle clear.
               shadow[ci]       <= ch_period[ci*DW +: DW];
               shadow_stale[ci] <= (wd[ci] == STALE_MAX);
               ci               <= ci + CHW'(1);
               if (ci == CI_LAST) state <= COMMIT;
            end
            COMMIT: begin
               for (int k = 0; k < NUM_CH; k++) readbuf[k] <= shadow[k];
               stale_q    <= shadow_stale;
               seq_q      <= seq_q + 8'd1;
               rd_valid_q <= 1'b1;
               busy_q     <= 1'b0;
               snap_ack_q <= 1'b1;
               state      <= ACK;
            end
            ACK: begin
               if (!bus.snap_req) begin
                  snap_ack_q <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   // Registered read port; out-of-range selects read as zero.
   always_ff @(posedge clk_fast or negedge reset) begin
      if (!reset)                        rd_data_q <= '0;
      else if (32'(bus.rd_sel) < NUM_CH) rd_data_q <= readbuf[bus.rd_sel];
      else                               rd_data_q <= '0;
   end

endmodule

// File: doc/enc_period_snapshot_ctrl.md
Name: enc_period_snapshot_ctrl

Overview:
- Sequences coherent snapshots of the per-channel encoder period words for the bus read path, on host request.
- Walks the channels in order and captures each period word into a shadow buffer.
- Commits the shadow buffer atomically to a read buffer and completes a req/ack handshake.
- Runs a per-channel staleness watchdog so software can tell a stopped encoder from a slow one. Sits between the per-channel period measurement units and the board register file.

Parameters:
NUM_CH, 4, number of encoder channels serviced
DW, 32, width of one period word
CHW, 2, channel index width (must be >= clog2(NUM_CH))
STALE_MAX, 16'hFFFF, clk_fast cycles without an update before a channel is flagged stale

Ports:
clk_fast  in  1  fast measurement clock
reset  in  1  asynchronous, active-low
ch_period  in  NUM_CH*DW  period words; channel k occupies bits [k*DW +: DW]
ch_update  in  NUM_CH  one-cycle pulse per channel when its period word is refreshed
snap_req  in  1  snapshot request level, already synchronized to clk_fast
snap_ack  out  1  snapshot complete; held until snap_req deasserts
busy  out  1  high in SAMPLE and COMMIT
rd_sel  in  CHW  read channel select
rd_data  out  DW  committed period word of rd_sel, registered
rd_valid  out  1  at least one snapshot committed since reset
stale  out  NUM_CH  committed stale flags, one per channel
seq  out  8  committed snapshot sequence number

Behaviour:
- Reset (async, reset==0):
  - state=IDLE; snap_ack, busy, rd_valid = 0.
  - rd_data, stale, seq, both buffers and all watchdogs = 0.
  - Reset mid-SAMPLE aborts the snapshot; no partial commit is visible.
- FSM states: IDLE, SAMPLE, COMMIT, ACK.
  - IDLE -> SAMPLE on snap_req rising edge. Edge is detected against a registered copy of snap_req that resets to 0. Channel index ci=0.
  - SAMPLE, one channel per cycle:
    - shadow[ci] <= ch_period[ci] as present that cycle.
    - shadow_stale[ci] <= (wd[ci] == STALE_MAX).
    - ci increments. After ci == NUM_CH-1 -> COMMIT. Duration is exactly NUM_CH cycles.
  - COMMIT, one cycle:
    - read buffer <= shadow; stale <= shadow_stale.
    - seq <= seq+1, wrapping 8'hFF -> 8'h00.
    - rd_valid <= 1 (sticky until reset). -> ACK.
  - ACK: snap_ack=1. Stay in ACK while snap_req==1; go to IDLE when snap_req==0, where snap_ack drops on that transition.
  - A snap_req that stays high after ACK does not retrigger. A new rising edge is required.
  - snap_req dropping during SAMPLE/COMMIT does not abort. The FSM still goes through ACK and leaves ACK on the first cycle snap_req is low.
- busy = (state==SAMPLE || state==COMMIT), registered with the state.
- Latency: rising edge of snap_req sampled at cycle 0 -> snap_ack high at cycle NUM_CH+2.
- Watchdog, per channel, independent of the FSM:
  - ch_update[k]=1 -> wd[k] <= 0.
  - Otherwise, if wd[k] != STALE_MAX, wd[k] increments. It saturates and does not wrap.
- Simultaneous update and sample of the same channel: the shadow takes the ch_period value present that cycle. The stale flag uses the pre-clear wd value. Updates to other channels during SAMPLE do not alter captured entries.
- Read path:
  - rd_data <= readbuf[rd_sel] every clock, 1-cycle latency.
  - rd_sel >= NUM_CH -> rd_data <= 0.
  - The read buffer changes only in COMMIT, so reads are coherent; a read in the COMMIT cycle returns the new value one cycle later.
- Period word content is passed through unmodified; no arithmetic on DW fields.

Test Plan:
- Reset then idle: all outputs 0, rd_valid=0. With rd_sel=0, rd_data=0.
- Snapshot order and atomicity:
  - Stimulus: ch_period = {32'h4,32'h3,32'h2,32'h1}; pulse snap_req 1->held. During SAMPLE cycle 1, change ch0 to 32'hAA.
  - Response: snap_ack at cycle 6; seq=1; rd_sel 0..3 read 1,2,3,4. Ch0 was already sampled before the change, so it reads 1.
  - A second snapshot reads ch0=32'hAA and seq=2.
- Handshake:
  - Hold snap_req high 20 cycles after ack -> no second snapshot; seq stays 1; snap_ack stays high.
  - Drop snap_req -> snap_ack low the next cycle; state IDLE.
- Staleness with STALE_MAX=16'h000F (test override):
  - Stimulus: pulse ch_update[2] every 5 cycles; never pulse ch0, ch1, ch3; snapshot after 40 cycles.
  - Response: stale=4'b1011.
- Seq wrap: run 256 snapshots -> seq returns to 8'h00; rd_valid remains 1.
- Reset mid-SAMPLE:
  - Stimulus: assert reset at SAMPLE cycle 2 after one committed snapshot (seq=1).
  - Response: all outputs 0 immediately, rd_valid=0, seq=0. A new snapshot after reset completes normally with seq=1.
